pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 4-stage core (Fetch, Decode, Ex, M/Wb).
- Drives the enable and flush controls of the F/D and D/Ex latches.
- Selects operand forwarding from the Ex/M and M/Wb latches.
- Runs the multi-cycle interrupt-entry sequence: drain, push PC, load vector.

Parameters:
- DRAIN_CYC, 2: cycles fetch is held off before the interrupt push, so older instructions retire.
- VEC_W, 2: width of the interrupt-entry step code.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- de_ra  in  2  Decode source register A.
- de_rb  in  2  Decode source register B.
- de_use_a  in  1  Decode instruction reads ra.
- de_use_b  in  1  Decode instruction reads rb.
- ex_rw  in  1  Ex-stage instruction writes a register.
- ex_rd  in  2  Ex-stage destination register.
- ex_load  in  1  Ex-stage instruction is a memory load (data available only after M).
- m_rw  in  1  Ex/M latch RW.
- m_rd  in  2  Ex/M latch destination (ra field).
- br_taken  in  1  branch or jump resolved taken in Ex.
- intr_req  in  1  level interrupt request.
- pc_en  out  1  PC update enable.
- fd_en  out  1  F/D latch enable.
- fd_flush  out  1  F/D latch loads a NOP.
- de_flush  out  1  D/Ex latch loads a NOP (bubble).
- fwd_a  out  2  operand A source: 0 = regfile, 1 = Ex/M, 2 = M/Wb.
- fwd_b  out  2  operand B source, same encoding as fwd_a.
- int_step  out  VEC_W  0 = none, 1 = push PC (SP decrement), 2 = PC <= vector.
- intr_ack  out  1  one-cycle acknowledge pulse.

Behaviour:
- Reset: while rst_n = 0 and after release, state = RUN, drain counter = 0, intr_ack = 0, int_step = 0.
- Reset: while rst_n = 0 only, pc_en = 0, fd_en = 0, fd_flush = 1, de_flush = 1, fwd_a = fwd_b = 0.
- Reset mid-sequence: aborts the interrupt entry immediately; the interrupt is not acknowledged.
- Forwarding is combinational.
  - A source matches if de_use_x is set and m_rw && m_rd == src: select 1.
  - Otherwise, if the M/Wb copy (internally registered m_rw/m_rd, one cycle delayed) matches: select 2.
  - Otherwise select 0. The Ex/M match has priority over M/Wb.
- Load-use stall: ex_load && ex_rw && (de_use_a && ex_rd == de_ra || de_use_b && ex_rd == de_rb).
  - Effect: pc_en = 0, fd_en = 0, de_flush = 1 for exactly 1 cycle.
  - Next cycle the producer is in Ex/M and is forwarded with select 1.
- Branch taken: fd_flush = 1, de_flush = 1, pc_en = 1 (target load).
  - Takes priority over a load-use stall in the same cycle; the stall is discarded.
- FSM states: RUN, DRAIN, PUSH, VEC.
- RUN -> DRAIN: on intr_req = 1, with no load-use stall and no br_taken in the same cycle.
  - If either is present, entry is deferred one cycle.
  - Counter is loaded with DRAIN_CYC - 1.
- DRAIN: pc_en = 0, fd_en = 0, fd_flush = 1, de_flush = 1; counter decrements.
  - If br_taken occurs, pc_en = 1 for that cycle only, so the pushed PC is the branch target.
  - Counter reaching 0 -> PUSH.
- PUSH, 1 cycle: int_step = 1; fetch held; flushes asserted. -> VEC.
- VEC, 1 cycle: int_step = 2, pc_en = 1, intr_ack = 1, fd_flush = 1. -> RUN.
- intr_req held high after intr_ack does not re-enter until it is seen low for at least one cycle; an internal armed flag tracks this.
- Default in RUN with no hazard: pc_en = fd_en = 1, flushes = 0.
- Register index width is fixed at 2; all register compares are full-width equality.

Decomposition:
- Shared package pipe_pkg holds:
  - FSM state enum (RUN, DRAIN, PUSH, VEC);
  - the int_step codes NONE/PUSH/VEC;
  - the forwarding select codes FWD_RF/FWD_EXM/FWD_MWB.
- One sub-module, fwd_unit: the combinational source compare, instantiated once per operand.
- The FSM, counter, M/Wb shadow registers and stall/flush priority logic stay in the top module.

Test Plan:
- Forwarding: m_rw = 1, m_rd = 2, de_ra = 2, de_use_a = 1 -> fwd_a = 1; same pattern one cycle later with m_rw = 0 -> fwd_a = 2.
- Load-use: ex_load = 1, ex_rw = 1, ex_rd = 1, de_rb = 1, de_use_b = 1 -> one cycle of pc_en = 0, fd_en = 0, de_flush = 1; next cycle fwd_b = 1.
- Branch plus stall in the same cycle: br_taken = 1 with a load-use condition -> fd_flush = de_flush = 1, pc_en = 1, no following stall cycle.
- Interrupt with DRAIN_CYC = 2: intr_req rises in RUN.
  - 2 DRAIN cycles with pc_en = 0.
  - int_step = 1, then int_step = 2 with intr_ack = 1.
  - Back to RUN; intr_req held high -> no second entry until it drops and rises again.
- Branch during DRAIN: br_taken in the first drain cycle -> pc_en = 1 that cycle only; PUSH still occurs at cycle 3.
- Reset mid-sequence: rst_n = 0 during PUSH -> outputs at reset values immediately; after release the state is RUN and intr_ack is never pulsed.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and codes for the pipeline hazard / interrupt-entry controller.
package pipe_pkg;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_PUSH  = 2'd2,
      ST_VEC   = 2'd3
   } seq_state_e;

   // Interrupt-entry step codes driven on int_step
   localparam int STEP_NONE = 0;
   localparam int STEP_PUSH = 1;
   localparam int STEP_VEC  = 2;

   // Operand forwarding source selects
   typedef enum logic [1:0] {
      FWD_RF  = 2'd0,
      FWD_EXM = 2'd1,
      FWD_MWB = 2'd2
   } fwd_sel_e;

   localparam int REG_W = 2;

endpackage

// File: rtl/fwd_unit.sv
// Operand source compare for one Decode operand: picks the youngest matching
// producer, Ex/M over M/Wb, else the register file.
module fwd_unit
   import pipe_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             use_src,
   input  logic             exm_rw,
   input  logic [REG_W-1:0] exm_rd,
   input  logic             mwb_rw,
   input  logic [REG_W-1:0] mwb_rd,
   output logic [1:0]       sel
);

   // priority compare; Ex/M holds the newer value so it wins
   always_comb begin
      sel = FWD_RF;
      if (use_src && exm_rw && (exm_rd == src)) begin
         sel = FWD_EXM;
      end else if (use_src && mwb_rw && (mwb_rd == src)) begin
         sel = FWD_MWB;
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: F/D and D/Ex enables/flushes, operand forwarding
// selects, load-use stall, taken-branch flush and interrupt entry.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | normal issue; hazards handled, interrupt may be accepted
//  ST_DRAIN | fetch held, older instructions retire; counter runs down
//  ST_PUSH  | push PC (SP decrement), fetch held
//  ST_VEC   | PC <= vector, acknowledge pulse, back to RUN
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int DRAIN_CYC = 2,
   parameter int VEC_W     = 2
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [REG_W-1:0] de_ra,
   input  logic [REG_W-1:0] de_rb,
   input  logic             de_use_a,
   input  logic             de_use_b,
   input  logic             ex_rw,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_load,
   input  logic             m_rw,
   input  logic [REG_W-1:0] m_rd,
   input  logic             br_taken,
   input  logic             intr_req,
   output logic             pc_en,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             de_flush,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [VEC_W-1:0] int_step,
   output logic             intr_ack
);

   localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

   seq_state_e       state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             armed;
   logic             mwb_rw;
   logic [REG_W-1:0] mwb_rd;
   logic             stall;
   logic             accept;
   logic [1:0]       sel_a, sel_b;

   fwd_unit u_fwd_a (
      .src     (de_ra),
      .use_src (de_use_a),
      .exm_rw  (m_rw),
      .exm_rd  (m_rd),
      .mwb_rw  (mwb_rw),
      .mwb_rd  (mwb_rd),
      .sel     (sel_a)
   );

   fwd_unit u_fwd_b (
      .src     (de_rb),
      .use_src (de_use_b),
      .exm_rw  (m_rw),
      .exm_rd  (m_rd),
      .mwb_rw  (mwb_rw),
      .mwb_rd  (mwb_rd),
      .sel     (sel_b)
   );

   // selects are held at the regfile while the core is in reset
   assign fwd_a = rst_n ? sel_a : FWD_RF;
   assign fwd_b = rst_n ? sel_b : FWD_RF;

   assign stall = ex_load && ex_rw &&
                  ((de_use_a && (ex_rd == de_ra)) || (de_use_b && (ex_rd == de_rb)));

   // an interrupt is only taken on a clean RUN cycle; otherwise it waits a cycle
   assign accept = intr_req && armed && !stall && !br_taken;

   // M/Wb shadow of the Ex/M write-back fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mwb_rw <= 1'b0;
         mwb_rd <= '0;
      end else begin
         mwb_rw <= m_rw;
         mwb_rd <= m_rd;
      end
   end

   // state, drain counter and re-arm flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
         cnt   <= '0;
         armed <= 1'b1;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (state == ST_VEC) begin
            armed <= 1'b0;
         end else if (!intr_req) begin
            armed <= 1'b1;
         end
      end
   end

   // next state and pipeline controls; branch flush beats load-use stall
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_en     = 1'b1;
      fd_en     = 1'b1;
      fd_flush  = 1'b0;
      de_flush  = 1'b0;
      int_step  = VEC_W'(STEP_NONE);
      intr_ack  = 1'b0;

      case (state)
         ST_RUN: begin
            if (br_taken) begin
               fd_flush = 1'b1;
               de_flush = 1'b1;
            end else if (stall) begin
               pc_en    = 1'b0;
               fd_en    = 1'b0;
               de_flush = 1'b1;
            end
            if (accept) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = CNT_W'(DRAIN_CYC - 1);
            end
         end
         ST_DRAIN: begin
            // a late taken branch still loads its target so the pushed PC is correct
            pc_en    = br_taken;
            fd_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            if (cnt == '0) begin
               state_nxt = ST_PUSH;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         ST_PUSH: begin
            pc_en     = 1'b0;
            fd_en     = 1'b0;
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            int_step  = VEC_W'(STEP_PUSH);
            state_nxt = ST_VEC;
         end
         ST_VEC: begin
            fd_flush  = 1'b1;
            int_step  = VEC_W'(STEP_VEC);
            intr_ack  = 1'b1;
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase

      if (!rst_n) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         fd_flush = 1'b1;
         de_flush = 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] de_ra, de_rb, ex_rd, m_rd;
   logic       de_use_a, de_use_b, ex_rw, ex_load, m_rw, br_taken, intr_req;
   logic       pc_en, fd_en, fd_flush, de_flush, intr_ack;
   logic [1:0] fwd_a, fwd_b, int_step;

   int checks   = 0;
   int failures = 0;

   // observed bundle: {pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, int_step, intr_ack}
   logic [10:0] obs, exp_v;
   assign obs = {pc_en, fd_en, fd_flush, de_flush, fwd_a, fwd_b, int_step, intr_ack};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.DRAIN_CYC(2), .VEC_W(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .de_ra    (de_ra),
      .de_rb    (de_rb),
      .de_use_a (de_use_a),
      .de_use_b (de_use_b),
      .ex_rw    (ex_rw),
      .ex_rd    (ex_rd),
      .ex_load  (ex_load),
      .m_rw     (m_rw),
      .m_rd     (m_rd),
      .br_taken (br_taken),
      .intr_req (intr_req),
      .pc_en    (pc_en),
      .fd_en    (fd_en),
      .fd_flush (fd_flush),
      .de_flush (de_flush),
      .fwd_a    (fwd_a),
      .fwd_b    (fwd_b),
      .int_step (int_step),
      .intr_ack (intr_ack)
   );

   task automatic idle_inputs();
      de_ra = 2'd0; de_rb = 2'd0; de_use_a = 1'b0; de_use_b = 1'b0;
      ex_rw = 1'b0; ex_rd = 2'd0; ex_load = 1'b0;
      m_rw = 1'b0; m_rd = 2'd0; br_taken = 1'b0;
   endtask

   task automatic next_slot();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; intr_req = 1'b0;
      idle_inputs();
      // a forwarding match is present but must be masked while in reset
      m_rw = 1'b1; m_rd = 2'd0; de_ra = 2'd0; de_use_a = 1'b1;
      next_slot(); #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL reset_hold: got %b want %b", obs, exp_v); end
      next_slot();
      idle_inputs();
      rst_n = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL reset_release: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_forwarding();
      next_slot(); idle_inputs();
      m_rw = 1'b1; m_rd = 2'd2; de_ra = 2'd2; de_use_a = 1'b1; de_rb = 2'd0; de_use_b = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_exm: got %b want %b", obs, exp_v); end
      next_slot();
      m_rw = 1'b0; de_rb = 2'd2; de_use_b = 1'b0; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_mwb: got %b want %b", obs, exp_v); end
      next_slot();
      m_rw = 1'b1; m_rd = 2'd3; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_none: got %b want %b", obs, exp_v); end
      next_slot();
      de_ra = 2'd3; de_rb = 2'd3; de_use_b = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_priority: got %b want %b", obs, exp_v); end
      next_slot();
      m_rw = 1'b0; de_use_b = 1'b0; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL fwd_mwb_b_unused: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_load_use();
      next_slot(); idle_inputs();
      ex_load = 1'b1; ex_rw = 1'b1; ex_rd = 2'd1; de_rb = 2'd1; de_use_b = 1'b0; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL lu_unused_operand: got %b want %b", obs, exp_v); end
      next_slot();
      de_use_b = 1'b1; #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL lu_stall: got %b want %b", obs, exp_v); end
      next_slot();
      ex_load = 1'b0; ex_rw = 1'b0; m_rw = 1'b1; m_rd = 2'd1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL lu_forward: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_branch_stall();
      next_slot(); idle_inputs();
      ex_load = 1'b1; ex_rw = 1'b1; ex_rd = 2'd2; de_ra = 2'd2; de_use_a = 1'b1; br_taken = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL br_over_stall: got %b want %b", obs, exp_v); end
      next_slot(); idle_inputs(); #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL br_no_late_stall: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_interrupt();
      next_slot(); idle_inputs();
      intr_req = 1'b1; br_taken = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL int_deferred_br: got %b want %b", obs, exp_v); end
      next_slot(); br_taken = 1'b0; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL int_accept_run: got %b want %b", obs, exp_v); end
      for (int i = 0; i < 2; i++) begin
         next_slot(); #1;
         checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
         if (obs !== exp_v) begin failures++; $display("FAIL int_drain%0d: got %b want %b", i, obs, exp_v); end
      end
      next_slot(); #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL int_push: got %b want %b", obs, exp_v); end
      next_slot(); #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1};
      if (obs !== exp_v) begin failures++; $display("FAIL int_vec: got %b want %b", obs, exp_v); end
      for (int i = 0; i < 3; i++) begin
         next_slot();
         if (i == 2) intr_req = 1'b0;
         #1;
         checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
         if (obs !== exp_v) begin failures++; $display("FAIL int_no_reentry%0d: got %b want %b", i, obs, exp_v); end
      end
      // second request: branch lands in the first drain cycle
      next_slot(); intr_req = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL int2_accept: got %b want %b", obs, exp_v); end
      next_slot(); br_taken = 1'b1; #1;
      checks++; exp_v = {1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL drain_branch: got %b want %b", obs, exp_v); end
      next_slot(); br_taken = 1'b0; #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL drain_after_branch: got %b want %b", obs, exp_v); end
      next_slot(); #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL int2_push: got %b want %b", obs, exp_v); end
      next_slot(); #1;
      checks++; exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 2'd2, 1'b1};
      if (obs !== exp_v) begin failures++; $display("FAIL int2_vec: got %b want %b", obs, exp_v); end
   endtask

   task automatic test_reset_mid_sequence();
      next_slot(); intr_req = 1'b0;
      next_slot(); intr_req = 1'b1;
      for (int i = 0; i < 3; i++) next_slot();
      #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd1, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL rst_pre_push: got %b want %b", obs, exp_v); end
      #1 rst_n = 1'b0; #1;
      checks++; exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0};
      if (obs !== exp_v) begin failures++; $display("FAIL rst_mid_push: got %b want %b", obs, exp_v); end
      intr_req = 1'b0;
      next_slot(); rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; exp_v = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0};
         if (obs !== exp_v) begin failures++; $display("FAIL rst_after%0d: got %b want %b", i, obs, exp_v); end
         next_slot();
      end
   endtask

   initial begin
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_stall();
      test_interrupt();
      test_reset_mid_sequence();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
